adc_scan_sequencer: RTL

//  Scan controller in front of pwm_adc. Steps an external analog mux over up to NUM_CH inputs.
//  Per channel: waits a settling time, enables the ADC (ramp or SA mode), drops the first result,
//  and averages 2**AVG_LOG2 results. Each averaged result goes out on a valid/ready stream.

---
 rtl/adc_seq_pkg.sv | 39 +++
 rtl/adc_accumulator.sv | 34 +++
 rtl/adc_scan_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types for the ADC scan sequencer: FSM state encoding and the
// channel-pick helper used to walk the enabled-channel mask.
package adc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_ARM     = 3'd3,
    S_DISCARD = 3'd4,
    S_CONVERT = 3'd5,
    S_EMIT    = 3'd6,
    S_NEXT    = 3'd7
  } state_t;

  // Widest mask the helper understands; NUM_CH must not exceed this.
  localparam int MAX_CH = 16;
  localparam int IDX_W  = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } ch_pick_t;

  // Lowest set bit of mask at or above position 'from'.
  function automatic ch_pick_t next_enabled_ch(input logic [MAX_CH-1:0] mask,
                                               input logic [IDX_W:0]    from);
    ch_pick_t pick;
    pick = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) begin
        pick.found = 1'b1;
        pick.idx   = IDX_W'(i);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adc_accumulator.sv
// Sums 2**AVG_LOG2 ADC samples and presents the truncated mean.
module adc_accumulator #(
  parameter int AVG_LOG2 = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add,
  input  logic [15:0] data,
  output logic        done,
  output logic [15:0] result
);

  localparam int ACC_W = 16 + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;

  logic [ACC_W-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign done   = (cnt_reg == CNT_W'(NSAMP));
  assign result = acc_reg[ACC_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      acc_reg <= '0;
      cnt_reg <= '0;
    end else if (add && !done) begin
      acc_reg <= acc_reg + ACC_W'(data);
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scan controller for pwm_adc: steps the analog mux over enabled channels,
// settles, discards the first conversion, averages, and streams results.
module adc_scan_sequencer
  import adc_seq_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SETTLE_CYC  = 1000,
  parameter int AVG_LOG2    = 2,
  parameter int TIMEOUT_CYC = 200_000,
  parameter int CH_W        = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              continuous,
  input  logic              mode_sa,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  output logic [CH_W-1:0]   mux_sel,
  output logic              adc_pwm_en,
  output logic              adc_sa_en,
  input  logic              adc_data_ready,
  input  logic [15:0]       adc_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [15:0]       res_data,
  output logic              timeout_err
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_t              state_reg, state_next;
  logic [NUM_CH-1:0]   mask_reg;
  logic                mode_reg;
  logic [CH_W:0]       ptr_reg;
  logic [SET_W-1:0]    settle_cnt_reg;
  logic [TO_W-1:0]     to_cnt_reg;
  logic                rdy_q_reg;

  logic                busy_reg, pwm_en_reg, sa_en_reg, res_valid_reg, timeout_err_reg;
  logic [CH_W-1:0]     mux_sel_reg, res_ch_reg;
  logic [15:0]         res_data_reg;

  logic                rdy_edge, settle_done, to_expired, rescan;
  logic                acc_clear, acc_add, acc_done;
  logic [15:0]         acc_result;
  ch_pick_t            pick_cur, pick_nxt;

  adc_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .add    (acc_add),
    .data   (adc_data),
    .done   (acc_done),
    .result (acc_result)
  );

  always_comb begin
    rdy_edge    = adc_data_ready && !rdy_q_reg;
    settle_done = (settle_cnt_reg == SET_W'(SETTLE_CYC - 1));
    to_expired  = !rdy_edge && (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
    pick_cur    = next_enabled_ch(MAX_CH'(mask_reg), (IDX_W + 1)'(ptr_reg));
    pick_nxt    = next_enabled_ch(MAX_CH'(mask_reg), (IDX_W + 1)'(ptr_reg + (CH_W + 1)'(1)));
    rescan      = continuous && (|ch_mask);
  end

  always_comb begin
    state_next = state_reg;
    acc_clear  = 1'b0;
    acc_add    = 1'b0;
    case (state_reg)
      S_IDLE:    if (start && (|ch_mask)) state_next = S_SELECT;
      S_SELECT:  state_next = pick_cur.found ? S_SETTLE : S_IDLE;
      S_SETTLE:  if (settle_done) state_next = S_ARM;
      S_ARM: begin
        acc_clear  = 1'b1;
        state_next = S_DISCARD;
      end
      S_DISCARD: begin
        if (rdy_edge)        state_next = S_CONVERT;
        else if (to_expired) state_next = S_NEXT;
      end
      S_CONVERT: begin
        if (acc_done)        state_next = S_EMIT;
        else if (rdy_edge)   acc_add    = 1'b1;
        else if (to_expired) state_next = S_NEXT;
      end
      S_EMIT:    if (res_valid_reg && res_ready) state_next = S_NEXT;
      S_NEXT:    state_next = (pick_nxt.found || rescan) ? S_SELECT : S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      mask_reg        <= '0;
      mode_reg        <= 1'b0;
      ptr_reg         <= '0;
      settle_cnt_reg  <= '0;
      to_cnt_reg      <= '0;
      rdy_q_reg       <= 1'b0;
      busy_reg        <= 1'b0;
      pwm_en_reg      <= 1'b0;
      sa_en_reg       <= 1'b0;
      res_valid_reg   <= 1'b0;
      timeout_err_reg <= 1'b0;
      mux_sel_reg     <= '0;
      res_ch_reg      <= '0;
      res_data_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      rdy_q_reg     <= adc_data_ready;
      busy_reg      <= (state_next != S_IDLE);
      // Enables follow the next state, so they are already off in EMIT and on a timeout.
      pwm_en_reg    <= (state_next inside {S_ARM, S_DISCARD, S_CONVERT});
      sa_en_reg     <= (state_next inside {S_ARM, S_DISCARD, S_CONVERT}) && mode_reg;
      res_valid_reg <= (state_next == S_EMIT);
      timeout_err_reg <= ((state_reg == S_DISCARD) || (state_reg == S_CONVERT)) &&
                         (state_next == S_NEXT);

      case (state_reg)
        S_IDLE: begin
          if (start && (|ch_mask)) begin
            mask_reg <= ch_mask;
            mode_reg <= mode_sa;
            ptr_reg  <= '0;
          end
        end
        S_SELECT: begin
          if (pick_cur.found) begin
            mux_sel_reg <= CH_W'(pick_cur.idx);
            ptr_reg     <= (CH_W + 1)'(pick_cur.idx);
          end
          settle_cnt_reg <= '0;
        end
        S_SETTLE:  settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
        S_ARM:     to_cnt_reg <= '0;
        S_DISCARD: to_cnt_reg <= rdy_edge ? '0 : to_cnt_reg + TO_W'(1);
        S_CONVERT: begin
          to_cnt_reg <= rdy_edge ? '0 : to_cnt_reg + TO_W'(1);
          if (acc_done) begin
            res_ch_reg   <= mux_sel_reg;
            res_data_reg <= acc_result;
          end
        end
        S_NEXT: begin
          if (pick_nxt.found) begin
            ptr_reg <= ptr_reg + (CH_W + 1)'(1);
          end else if (rescan) begin
            mask_reg <= ch_mask;
            mode_reg <= mode_sa;
            ptr_reg  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_reg;
  assign mux_sel     = mux_sel_reg;
  assign adc_pwm_en  = pwm_en_reg;
  assign adc_sa_en   = sa_en_reg;
  assign res_valid   = res_valid_reg;
  assign res_ch      = res_ch_reg;
  assign res_data    = res_data_reg;
  assign timeout_err = timeout_err_reg;

endmodule
